// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector with a registered
// one-cycle match pulse, overlap control and a saturating match counter.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0001_0101,
    parameter int DEF_LEN = 5,
    parameter bit DEF_OVERLAP = 1'b1,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ip,
    input  logic               ip_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               op,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               active
);
    typedef enum logic {ACTIVE, DISABLED} state_t;

    state_t             state, state_next;
    logic [MAX_LEN-1:0] pattern, hist, cand, mask;
    logic [LW-1:0]      len, fill, len_new;
    logic               overlap, sample, match;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) mask[i] = i < int'(len);
        cand = {hist[MAX_LEN-2:0], ip};
        sample = state == ACTIVE && ip_valid && !cfg_load;
        // fill counts bits already held, so the incoming bit completes len when fill+1 >= len
        match = sample && ({1'b0, fill} + (LW+1)'(1) >= {1'b0, len}) && ((cand ^ pattern) & mask) == '0;
        len_new = cfg_len > LW'(MAX_LEN) ? LW'(MAX_LEN) : cfg_len;
        state_next = cfg_load ? (cfg_len == '0 ? DISABLED : ACTIVE) : state;
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= DEF_LEN == 0 ? DISABLED : ACTIVE;
        else state <= state_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pattern   <= DEF_PATTERN;
            len       <= LW'(DEF_LEN);
            overlap   <= DEF_OVERLAP;
            hist      <= '0;
            fill      <= '0;
            op        <= 1'b0;
            match_cnt <= '0;
        end else begin
            op <= match;
            match_cnt <= cnt_clr ? CNT_W'(match) : (match && !(&match_cnt)) ? match_cnt + 1'b1 : match_cnt;
            if (cfg_load) begin
                pattern <= cfg_pattern;
                len     <= len_new;
                overlap <= cfg_overlap;
                hist    <= '0;
                fill    <= '0;
            end else if (sample) begin
                hist <= cand;
                fill <= (match && !overlap) ? '0 : fill == LW'(MAX_LEN) ? fill : fill + 1'b1;
            end
        end
    end

    assign active = state == ACTIVE;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed stimulus with a bit-queue reference model feeding a
// scoreboard of expected op/match_cnt/active per cycle.
module tb_seq_detector_param;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ip = 1'b0, ip_valid = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0, cnt_clr = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       op, active;
    logic [1:0] match_cnt;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut (
        .clk(clk), .resetn(resetn), .ip(ip), .ip_valid(ip_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .op(op), .match_cnt(match_cnt), .active(active)
    );

    always #5 clk = ~clk;

    typedef struct {logic o; logic [1:0] c; logic a;} exp_t;
    exp_t sb[$];

    int tests = 0, fails = 0;
    logic [7:0] m_pat;
    int m_len, m_cnt;
    bit m_ovl, m_act;
    bit q[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pat = 8'h15; m_len = 5; m_ovl = 1; m_act = 1; m_cnt = 0;
        q.delete();
    endtask

    task automatic cyc(input logic b, input logic v, input logic clr, input logic ld,
                       input logic [7:0] pat, input logic [3:0] ln, input logic ovl);
        bit mt;
        exp_t e;
        ip = b; ip_valid = v; cnt_clr = clr; cfg_load = ld;
        cfg_pattern = pat; cfg_len = ln; cfg_overlap = ovl;
        mt = 0;
        if (ld) begin
            m_pat = pat; m_len = ln > 8 ? 8 : int'(ln); m_ovl = ovl; m_act = ln != 0;
            q.delete();
        end else if (m_act && v) begin
            q.push_back(b);
            if (q.size() > 8) void'(q.pop_front());
            if (q.size() >= m_len) begin
                mt = 1;
                for (int k = 0; k < m_len; k++) if (q[q.size()-1-k] != m_pat[k]) mt = 0;
            end
            if (mt && !m_ovl) q.delete();
        end
        m_cnt = clr ? int'(mt) : (mt && m_cnt < 3) ? m_cnt + 1 : m_cnt;
        sb.push_back('{o: mt, c: 2'(m_cnt), a: m_act});
        @(posedge clk);
        #1;
        cfg_load = 0; cnt_clr = 0;
        e = sb.pop_front();
        chk("op", 8'(op), 8'(e.o));
        chk("match_cnt", 8'(match_cnt), 8'(e.c));
        chk("active", 8'(active), 8'(e.a));
    endtask

    task automatic bit_in(input logic b);
        cyc(b, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic clr();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] ln, input logic ovl);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, pat, ln, ovl);
    endtask

    task automatic stream(input logic [15:0] s, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(s[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        chk("reset_op", 8'(op), 8'h0);
        chk("reset_cnt", 8'(match_cnt), 8'h0);
        chk("reset_active", 8'(active), 8'h1);

        // default overlapping 10101: matches after bits 5 and 7
        stream(16'b1010101, 7);
        chk("dflt_cnt", 8'(match_cnt), 8'd2);

        clr();
        load(8'b10101, 4'd5, 1'b0);
        stream(16'b10101010101, 11);
        chk("novl_cnt", 8'(match_cnt), 8'd2);

        // idle cycles between bits must not break a partial match
        clr();
        load(8'b110, 4'd3, 1'b1);
        bit_in(1'b1); idle(); idle(); idle();
        bit_in(1'b1); idle(); idle(); idle();
        bit_in(1'b0);
        chk("gap_cnt", 8'(match_cnt), 8'd1);

        load(8'b1, 4'd1, 1'b1);
        stream(16'b11111, 5);
        chk("sat_cnt", 8'(match_cnt), 8'd3);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        chk("clr_match_cnt", 8'(match_cnt), 8'd1);
        bit_in(1'b0);

        // reload mid-sequence discards the partial match
        clr();
        load(8'b10101, 4'd5, 1'b1);
        stream(16'b1010, 4);
        load(8'b10101, 4'd5, 1'b1);
        bit_in(1'b1);
        chk("reload_op", 8'(op), 8'h0);
        stream(16'b0101, 4);
        chk("post_reload_op", 8'(op), 8'h1);

        // async reset while op is high clears it immediately
        #2 resetn = 1'b0;
        #1;
        chk("arst_op", 8'(op), 8'h0);
        chk("arst_cnt", 8'(match_cnt), 8'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        model_reset();
        stream(16'b01, 2);
        chk("arst_lost_op", 8'(op), 8'h0);

        bit_in(1'b0);
        bit_in(1'b1);
        load(8'h00, 4'd0, 1'b1);
        stream(16'b10101, 5);
        chk("dis_active", 8'(active), 8'h0);
        clr();

        // oversized length clamps to the full 8-bit pattern
        load(8'b11001010, 4'd12, 1'b0);
        stream(16'b1100101011001010, 16);
        chk("clamp_cnt", 8'(match_cnt), 8'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
